// File: rtl/timer_sequencer.sv
// timer_sequencer
// Runs COUNT back-to-back intervals on a downstream interval timer for a
// single REQ/ACK request. The sequencer fires START, waits for the timer's
// one-cycle RDY, and counts completed intervals on TICKS. DONE pulses once
// after the last interval. ABORT cancels a running sequence. If an interval
// is in flight when ABORT arrives, the sequencer drains that interval so the
// timer is back in READY when IDLE is reached.
module timer_sequencer #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         REQ,
    input  logic [W-1:0] COUNT,
    input  logic         ABORT,
    output logic         ACK,
    output logic         START,
    input  logic         RDY,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] TICKS
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_FIRE   = 5'b00010,
        S_WAIT   = 5'b00100,
        S_FINISH = 5'b01000,
        S_DRAIN  = 5'b10000
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] ticks_q;
    logic [W-1:0] ticks_d;
    logic [W-1:0] ticks_inc;

    // ticks_q never exceeds cnt_q, so this W-bit increment cannot wrap
    assign ticks_inc = ticks_q + 1'b1;
    assign TICKS     = ticks_q;

    // State, latched count and completed-interval count registers
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ticks_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ticks_q <= ticks_d;
        end
    end

    // Next-state, register updates and outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ticks_d = ticks_q;
        ACK     = 1'b0;
        START   = 1'b0;
        DONE    = 1'b0;
        BUSY    = 1'b1;
        case (state_q)
            S_IDLE: begin
                BUSY = 1'b0;
                if (REQ && !ABORT) begin
                    ACK     = 1'b1;
                    cnt_d   = COUNT;
                    ticks_d = '0;
                    state_d = (COUNT == '0) ? S_FINISH : S_FIRE;
                end
            end
            S_FIRE: begin
                // ABORT gates START combinationally so an aborted fire never
                // reaches the timer
                START   = !ABORT;
                state_d = ABORT ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (RDY) begin
                    ticks_d = ticks_inc;
                    if (ABORT) begin
                        state_d = S_IDLE;
                    end else if (ticks_inc == cnt_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_FIRE;
                    end
                end else if (ABORT) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (RDY) begin
                    state_d = S_IDLE;
                end
            end
            S_FINISH: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                BUSY    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
